translation_tlb: RTL and testbench

- Parametrised successor to the single-cycle translation stage between axi_mmu_wrapper_sync (toMM_*/fromMM_* streams) and memory.
- Translates read and write virtual requests through a fully-associative TLB of ENTRIES pages.
- On a miss it issues a page-walk request on a stream port and fills the TLB from the response.
- Adds a fault flag, a flush input and hit/miss counters.

---
 rtl/translation_tlb.sv | 216 +++++++++++++++++++++
 tb/tb_translation_tlb.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/translation_tlb.sv
// Virtual-to-physical translation stage with a fully-associative TLB.
// Arbitrates read/write requests, walks pages on a miss and fills the TLB from the walk response.
module translation_tlb #(
  parameter int VA_W       = 32,
  parameter int PA_W       = 32,
  parameter int TAG_W      = 3,
  parameter int PAGE_SHIFT = 12,
  parameter int ENTRIES    = 8
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [TAG_W+8+VA_W-1:0]    axis_ird_tdata,
  input  logic                       axis_ird_tvalid,
  output logic                       axis_ird_tready,
  input  logic [TAG_W+8+VA_W-1:0]    axis_iwr_tdata,
  input  logic                       axis_iwr_tvalid,
  output logic                       axis_iwr_tready,
  output logic [PA_W:0]              axis_ord_tdata,
  output logic                       axis_ord_tvalid,
  input  logic                       axis_ord_tready,
  output logic [PA_W:0]              axis_owr_tdata,
  output logic                       axis_owr_tvalid,
  input  logic                       axis_owr_tready,
  output logic [VA_W-PAGE_SHIFT-1:0] walk_req_tdata,
  output logic                       walk_req_tvalid,
  input  logic                       walk_req_tready,
  input  logic [PA_W-PAGE_SHIFT:0]   walk_rsp_tdata,
  input  logic                       walk_rsp_tvalid,
  output logic                       walk_rsp_tready,
  input  logic                       flush,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
);

  localparam int VPN_W = VA_W - PAGE_SHIFT;
  localparam int PPN_W = PA_W - PAGE_SHIFT;
  localparam int REQ_W = TAG_W + 8 + VA_W;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WALK_REQ, S_WALK_RSP, S_RESP
  } state_t;

  state_t                 state_q;
  logic                   prio_q;      // 0: read favoured on contention
  logic                   req_wr_q;
  logic [VA_W-1:0]        req_va_q;
  logic [PA_W:0]          res_q;
  logic [ENTRIES-1:0]     valid_q;
  logic [VPN_W-1:0]       vpn_q [ENTRIES];
  logic [PPN_W-1:0]       ppn_q [ENTRIES];
  logic [IDX_W-1:0]       victim_q;
  logic                   ord_vld_q, owr_vld_q;
  logic [PA_W:0]          ord_data_q, owr_data_q;
  logic [31:0]            hit_cnt_q, miss_cnt_q;

  logic                   in_idle, rd_elig, wr_elig, grant_rd, grant_wr;
  logic [VA_W-1:0]        req_va_d;
  logic [VPN_W-1:0]       req_vpn;
  logic [PAGE_SHIFT-1:0]  req_off;
  logic [ENTRIES-1:0]     hit_vec;
  logic [PPN_W-1:0]       hit_ppn;
  logic                   hit;
  logic                   has_free;
  logic [IDX_W-1:0]       free_idx, fill_idx;
  logic                   rsp_ok, rsp_fire, fill_en;
  logic [PPN_W-1:0]       rsp_ppn;
  logic                   unused_req_bits;

  // tag and len ride along with the request but do not affect translation
  assign unused_req_bits = ^{axis_ird_tdata[REQ_W-1:VA_W], axis_iwr_tdata[REQ_W-1:VA_W]};

  assign in_idle  = (state_q == S_IDLE) && reset_;
  assign rd_elig  = axis_ird_tvalid && !ord_vld_q;
  assign wr_elig  = axis_iwr_tvalid && !owr_vld_q;
  assign grant_rd = in_idle && rd_elig && (!wr_elig || !prio_q);
  assign grant_wr = in_idle && wr_elig && (!rd_elig || prio_q);
  assign req_va_d = grant_wr ? axis_iwr_tdata[VA_W-1:0] : axis_ird_tdata[VA_W-1:0];

  assign req_vpn  = req_va_q[VA_W-1:PAGE_SHIFT];
  assign req_off  = req_va_q[PAGE_SHIFT-1:0];

  always_comb begin
    hit_vec = '0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == req_vpn)) begin
        hit_vec[i] = 1'b1;
        hit_ppn    = hit_ppn | ppn_q[i];
      end
    end
  end

  // A flush in the compare cycle must not let a soon-to-be-invalid entry hit
  assign hit = (|hit_vec) && !flush;

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign fill_idx = has_free ? free_idx : victim_q;
  assign rsp_ok   = walk_rsp_tdata[PPN_W];
  assign rsp_ppn  = walk_rsp_tdata[PPN_W-1:0];
  assign rsp_fire = (state_q == S_WALK_RSP) && walk_rsp_tvalid;
  assign fill_en  = rsp_fire && rsp_ok && !flush;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[fill_idx] <= req_vpn;
      ppn_q[fill_idx] <= rsp_ppn;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      req_wr_q   <= 1'b0;
      req_va_q   <= '0;
      res_q      <= '0;
      valid_q    <= '0;
      victim_q   <= '0;
      ord_vld_q  <= 1'b0;
      owr_vld_q  <= 1'b0;
      ord_data_q <= '0;
      owr_data_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ord_vld_q && axis_ord_tready) begin
        ord_vld_q  <= 1'b0;
        ord_data_q <= '0;
      end
      if (owr_vld_q && axis_owr_tready) begin
        owr_vld_q  <= 1'b0;
        owr_data_q <= '0;
      end

      if (flush) begin
        valid_q  <= '0;
        victim_q <= '0;
      end else if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
        if (!has_free) victim_q <= victim_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_rd || grant_wr) begin
            req_wr_q <= grant_wr;
            req_va_q <= req_va_d;
            prio_q   <= !prio_q;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            if (req_wr_q) begin
              owr_vld_q  <= 1'b1;
              owr_data_q <= {1'b0, hit_ppn, req_off};
            end else begin
              ord_vld_q  <= 1'b1;
              ord_data_q <= {1'b0, hit_ppn, req_off};
            end
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            state_q <= S_IDLE;
          end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            state_q <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (walk_req_tready) state_q <= S_WALK_RSP;
        end
        S_WALK_RSP: begin
          if (walk_rsp_tvalid) begin
            res_q   <= rsp_ok ? {1'b0, rsp_ppn, req_off} : {1'b1, {PA_W{1'b0}}};
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          // The originating channel's output register was empty at grant and nothing else writes it
          if (req_wr_q) begin
            owr_vld_q  <= 1'b1;
            owr_data_q <= res_q;
          end else begin
            ord_vld_q  <= 1'b1;
            ord_data_q <= res_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axis_ird_tready = grant_rd;
  assign axis_iwr_tready = grant_wr;
  assign axis_ord_tvalid = ord_vld_q;
  assign axis_ord_tdata  = ord_data_q;
  assign axis_owr_tvalid = owr_vld_q;
  assign axis_owr_tdata  = owr_data_q;
  assign walk_req_tvalid = (state_q == S_WALK_REQ);
  assign walk_req_tdata  = req_vpn;
  assign walk_rsp_tready = (state_q == S_WALK_RSP);
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;

endmodule

// File: tb/tb_translation_tlb.sv
// Directed self-checking bench for translation_tlb with the default parameter set.
module tb_translation_tlb;

  logic        clk = 1'b0;
  logic        reset_;
  logic [42:0] ird_tdata, iwr_tdata;
  logic        ird_tvalid, iwr_tvalid, ird_tready, iwr_tready;
  logic [32:0] ord_tdata, owr_tdata;
  logic        ord_tvalid, owr_tvalid, ord_tready, owr_tready;
  logic [19:0] walk_req_tdata;
  logic        walk_req_tvalid, walk_req_tready;
  logic [20:0] walk_rsp_tdata;
  logic        walk_rsp_tvalid, walk_rsp_tready;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int rd_acc = 0, wr_acc = 0, walk_cnt = 0;
  int exp_hit = 0, exp_miss = 0;
  localparam logic [10:0] TL = {3'd3, 8'd4};

  always #5 clk = ~clk;

  translation_tlb dut (
    .clk(clk), .reset_(reset_),
    .axis_ird_tdata(ird_tdata), .axis_ird_tvalid(ird_tvalid), .axis_ird_tready(ird_tready),
    .axis_iwr_tdata(iwr_tdata), .axis_iwr_tvalid(iwr_tvalid), .axis_iwr_tready(iwr_tready),
    .axis_ord_tdata(ord_tdata), .axis_ord_tvalid(ord_tvalid), .axis_ord_tready(ord_tready),
    .axis_owr_tdata(owr_tdata), .axis_owr_tvalid(owr_tvalid), .axis_owr_tready(owr_tready),
    .walk_req_tdata(walk_req_tdata), .walk_req_tvalid(walk_req_tvalid), .walk_req_tready(walk_req_tready),
    .walk_rsp_tdata(walk_rsp_tdata), .walk_rsp_tvalid(walk_rsp_tvalid), .walk_rsp_tready(walk_rsp_tready),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always @(posedge clk) begin
    if (ird_tvalid && ird_tready) rd_acc <= rd_acc + 1;
    if (iwr_tvalid && iwr_tready) wr_acc <= wr_acc + 1;
    if (walk_req_tvalid && walk_req_tready) walk_cnt <= walk_cnt + 1;
  end

  task automatic issue(input bit wr, input logic [31:0] va, output bit acc);
    int n;
    acc = 1'b0;
    n = 0;
    @(negedge clk);
    if (wr) begin iwr_tdata = {TL, va}; iwr_tvalid = 1'b1; end
    else    begin ird_tdata = {TL, va}; ird_tvalid = 1'b1; end
    while (!acc && n < 50) begin
      #1;
      if (wr ? iwr_tready : ird_tready) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    if (wr) iwr_tvalid = 1'b0; else ird_tvalid = 1'b0;
  endtask

  task automatic xact(input bit wr, input logic [31:0] va, input logic [20:0] rsp, input bit fl,
                      output logic [32:0] res, output logic [19:0] wvpn, output bit walked, output bit ok);
    bit acc, done;
    int n;
    res = '0; wvpn = '0; walked = 1'b0; done = 1'b0; n = 0;
    issue(wr, va, acc);
    while (acc && !done && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      if (walk_req_tvalid) begin
        walked = 1'b1;
        wvpn = walk_req_tdata;
        walk_req_tready = 1'b1;
        @(posedge clk);
        #1 walk_req_tready = 1'b0;
      end else if (walk_rsp_tready) begin
        walk_rsp_tvalid = 1'b1;
        walk_rsp_tdata = rsp;
        flush = fl;
        @(posedge clk);
        #1;
        walk_rsp_tvalid = 1'b0;
        flush = 1'b0;
      end else if (wr ? owr_tvalid : ord_tvalid) begin
        res = wr ? owr_tdata : ord_tdata;
        if (wr) owr_tready = 1'b1; else ord_tready = 1'b1;
        @(posedge clk);
        #1;
        owr_tready = 1'b0;
        ord_tready = 1'b0;
        done = 1'b1;
      end
    end
    ok = acc && done;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    ird_tvalid = 1'b1; iwr_tvalid = 1'b0; ird_tdata = '0; iwr_tdata = '0;
    ord_tready = 1'b0; owr_tready = 1'b0; walk_req_tready = 1'b0;
    walk_rsp_tvalid = 1'b0; walk_rsp_tdata = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ird_tready, iwr_tready, ord_tvalid, owr_tvalid, walk_req_tvalid, walk_rsp_tready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {ird_tready, iwr_tready, ord_tvalid, owr_tvalid, walk_req_tvalid, walk_rsp_tready});
    end
    checks++;
    if ({ord_tdata, owr_tdata, walk_req_tdata} !== 86'b0) begin
      errors++;
      $display("FAIL reset_data: ord %h owr %h walk %h want 0", ord_tdata, owr_tdata, walk_req_tdata);
    end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: hit %0d miss %0d want 0 0", hit_cnt, miss_cnt);
    end
    ird_tvalid = 1'b0;
    reset_ = 1'b1;
    @(negedge clk);
    ird_tvalid = 1'b1; iwr_tvalid = 1'b1;
    #1;
    checks++;
    if ({ird_tready, iwr_tready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_prio: rd/wr ready %b want 10", {ird_tready, iwr_tready});
    end
    #1;
    ird_tvalid = 1'b0; iwr_tvalid = 1'b0;
  endtask

  task automatic test_read_miss();
    logic [32:0] res; logic [19:0] wv; bit walked, ok;
    int w0;
    w0 = walk_cnt;
    xact(1'b0, 32'h0001_2345, {1'b1, 20'h00ABC}, 1'b0, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || wv !== 20'h00012) begin
      errors++;
      $display("FAIL rd_miss_walk: ok %0d walked %0d vpn %h want 1 1 00012", ok, walked, wv);
    end
    checks++;
    if (res !== 33'h0_00ABC345) begin
      errors++;
      $display("FAIL rd_miss_data: got %h want 000abc345", res);
    end
    checks++;
    if (walk_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL rd_miss_walkcnt: got %0d want 1", walk_cnt - w0);
    end
    checks++;
    if (miss_cnt !== exp_miss || hit_cnt !== exp_hit) begin
      errors++;
      $display("FAIL rd_miss_cnt: miss %0d hit %0d want %0d %0d", miss_cnt, hit_cnt, exp_miss, exp_hit);
    end
  endtask

  task automatic test_hit_latency();
    bit acc;
    int w0;
    w0 = walk_cnt;
    issue(1'b0, 32'h0001_2FFF, acc);
    exp_hit++;
    checks++;
    if (!acc || ord_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL hit_early: acc %0d tvalid %b want 1 0", acc, ord_tvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ord_tvalid !== 1'b1 || ord_tdata !== 33'h0_00ABCFFF) begin
      errors++;
      $display("FAIL hit_data: tvalid %b data %h want 1 000abcfff", ord_tvalid, ord_tdata);
    end
    ord_tready = 1'b1;
    @(posedge clk);
    #1 ord_tready = 1'b0;
    checks++;
    if (ord_tvalid !== 1'b0 || walk_cnt !== w0) begin
      errors++;
      $display("FAIL hit_clear: tvalid %b walks %0d want 0 %0d", ord_tvalid, walk_cnt, w0);
    end
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL hit_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_write_fault();
    logic [32:0] res; logic [19:0] wv; bit walked, ok;
    for (int k = 0; k < 2; k++) begin
      xact(1'b1, 32'h0005_0000, {1'b0, 20'h12345}, 1'b0, res, wv, walked, ok);
      exp_miss++;
      checks++;
      if (!ok || !walked || wv !== 20'h00050 || res !== 33'h1_0000_0000) begin
        errors++;
        $display("FAIL wr_fault[%0d]: ok %0d walked %0d vpn %h res %h want 1 1 00050 100000000",
                 k, ok, walked, wv, res);
      end
    end
    checks++;
    if (miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL wr_fault_cnt: miss %0d want %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] res; logic [19:0] wv; bit walked, ok;
    int g[8]; int gn, first, g0, wr_g, bad_stall, bad_data;
    bit full;
    xact(1'b1, 32'h0002_0010, {1'b1, 20'h00120}, 1'b0, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || res !== 33'h0_00120010) begin
      errors++;
      $display("FAIL b2b_fill: ok %0d walked %0d res %h want 1 1 000120010", ok, walked, res);
    end
    g0 = rd_acc + wr_acc;
    first = g0 % 2;
    gn = 0;
    @(negedge clk);
    ord_tready = 1'b1; owr_tready = 1'b1;
    ird_tdata = {TL, 32'h0001_2ABC}; iwr_tdata = {TL, 32'h0002_0010};
    ird_tvalid = 1'b1; iwr_tvalid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (gn < 8 && ird_tready) begin g[gn] = 0; gn++; end
      if (gn < 8 && iwr_tready) begin g[gn] = 1; gn++; end
      @(negedge clk);
    end
    checks++;
    if (gn < 4) begin
      errors++;
      $display("FAIL b2b_count: grants %0d want >=4", gn);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g[k] !== (first ^ (k % 2))) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got %0d want %0d (0=rd 1=wr)", k, g[k], first ^ (k % 2));
      end
    end
    ord_tready = 1'b0;
    full = 1'b0; wr_g = 0; bad_stall = 0; bad_data = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ord_tvalid) full = 1'b1;
      if (full && ird_tready) bad_stall++;
      if (full && ord_tdata !== 33'h0_00ABCABC) bad_data++;
      if (iwr_tready) wr_g++;
      @(negedge clk);
    end
    checks++;
    if (!full || bad_stall != 0 || ord_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: full %0d rd_grants_while_full %0d tvalid %b want 1 0 1", full, bad_stall, ord_tvalid);
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL b2b_stable: unstable cycles %0d data %h want 0 000abcabc", bad_data, ord_tdata);
    end
    checks++;
    if (wr_g < 5) begin
      errors++;
      $display("FAIL b2b_wr_continue: wr grants %0d want >=5", wr_g);
    end
    ird_tvalid = 1'b0; iwr_tvalid = 1'b0;
    ord_tready = 1'b1; owr_tready = 1'b1;
    repeat (6) @(negedge clk);
    ord_tready = 1'b0; owr_tready = 1'b0;
    exp_hit = exp_hit + (rd_acc + wr_acc - g0);
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL b2b_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_eviction();
    logic [32:0] res; logic [19:0] wv; bit walked, ok;
    logic [19:0] pp;
    logic [19:0] vv [6];
    logic [19:0] ep [6];
    bit          ew [6];
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      pp = 20'(256 + v);
      xact(1'b0, (32'(v) << 12) | 32'h34, {1'b1, pp}, 1'b0, res, wv, walked, ok);
      exp_miss++;
      checks++;
      if (!ok || !walked || wv !== 20'(v) || res !== {1'b0, pp, 12'h034}) begin
        errors++;
        $display("FAIL evict_fill[%0d]: ok %0d walked %0d vpn %h res %h want 1 1 %h %h",
                 v, ok, walked, wv, res, 20'(v), {1'b0, pp, 12'h034});
      end
    end
    // vpn 9 took entry 0 (vpn 1); vpn 1 then evicts vpn 2, and vpn 2 evicts vpn 3
    vv = '{20'h2, 20'h9, 20'h1, 20'h3, 20'h2, 20'h4};
    ep = '{20'h102, 20'h109, 20'h201, 20'h103, 20'h202, 20'h104};
    ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      xact(1'b0, {vv[k], 12'h034}, {1'b1, ep[k]}, 1'b0, res, wv, walked, ok);
      if (ew[k]) exp_miss++; else exp_hit++;
      checks++;
      if (!ok || walked !== ew[k] || res !== {1'b0, ep[k], 12'h034}) begin
        errors++;
        $display("FAIL evict_reuse[%0d]: ok %0d walked %0d res %h want 1 %0d %h",
                 k, ok, walked, res, ew[k], {1'b0, ep[k], 12'h034});
      end
    end
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL evict_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_flush_walk();
    logic [32:0] res; logic [19:0] wv; bit walked, ok;
    xact(1'b0, 32'h0007_7123, {1'b1, 20'h00777}, 1'b1, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || res !== 33'h0_00777123) begin
      errors++;
      $display("FAIL flush_first: ok %0d walked %0d res %h want 1 1 000777123", ok, walked, res);
    end
    xact(1'b0, 32'h0007_7123, {1'b1, 20'h00999}, 1'b0, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || res !== 33'h0_00999123) begin
      errors++;
      $display("FAIL flush_repeat: ok %0d walked %0d res %h want 1 1 000999123", ok, walked, res);
    end
    xact(1'b1, 32'h0000_4034, {1'b1, 20'h00444}, 1'b0, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || res !== 33'h0_00444034) begin
      errors++;
      $display("FAIL flush_old_gone: ok %0d walked %0d res %h want 1 1 000444034", ok, walked, res);
    end
  endtask

  task automatic test_reset_midwalk();
    logic [32:0] res; logic [19:0] wv; bit walked, ok, acc;
    int n, spur;
    issue(1'b0, 32'h0008_8000, acc);
    n = 0;
    while (!walk_req_tvalid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!acc || walk_req_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midwalk_reach: acc %0d walk_req_tvalid %b want 1 1", acc, walk_req_tvalid);
    end
    reset_ = 1'b0;
    #1;
    checks++;
    if (walk_req_tvalid !== 1'b0 || walk_rsp_tready !== 1'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin
      errors++;
      $display("FAIL midwalk_reset: walk_req %b walk_rsp_rdy %b hit %0d miss %0d want 0 0 0 0",
               walk_req_tvalid, walk_rsp_tready, hit_cnt, miss_cnt);
    end
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    exp_hit = 0; exp_miss = 0;
    ord_tready = 1'b1;
    spur = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (ord_tvalid || owr_tvalid || walk_req_tvalid) spur++;
    end
    ord_tready = 1'b0;
    checks++;
    if (spur != 0) begin
      errors++;
      $display("FAIL midwalk_no_result: active cycles %0d want 0", spur);
    end
    @(negedge clk);
    ird_tvalid = 1'b1; iwr_tvalid = 1'b1;
    #1;
    checks++;
    if ({ird_tready, iwr_tready} !== 2'b10) begin
      errors++;
      $display("FAIL midwalk_prio: rd/wr ready %b want 10", {ird_tready, iwr_tready});
    end
    #1;
    ird_tvalid = 1'b0; iwr_tvalid = 1'b0;
    xact(1'b0, 32'h0001_2345, {1'b1, 20'h00DEF}, 1'b0, res, wv, walked, ok);
    exp_miss++;
    checks++;
    if (!ok || !walked || res !== 33'h0_00DEF345 || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL midwalk_tlb_cleared: ok %0d walked %0d res %h miss %0d want 1 1 000def345 %0d",
               ok, walked, res, miss_cnt, exp_miss);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_hit_latency();
    test_write_fault();
    test_back_to_back();
    test_eviction();
    test_flush_walk();
    test_reset_midwalk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
